// File: rtl/dds_sweep_gen.sv
// dds_sweep_gen: DDS saw/tri/square generator with linear sweep and wrap-aligned retune; define DDS_SWEEP_GEN_OFFSET_SAT_EN to saturate the offset add
module dds_sweep_gen #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 12,
    parameter int AMP_W   = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               ClkEn,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_freq_start,
    input  logic [PHASE_W-1:0] cfg_freq_step,
    input  logic [15:0]        cfg_step_count,
    input  logic [15:0]        cfg_dwell,
    input  logic               cfg_loop,
    input  logic [1:0]         cfg_wave,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic [7:0]         cfg_duty,
    input  logic [DATA_W-1:0]  cfg_offset,
    input  logic               stop,
    output logic               busy,
    output logic               sweep_done,
    output logic [PHASE_W-1:0] freq_word,
    output logic [DATA_W-1:0]  out
);
    localparam int PW = DATA_W + AMP_W + 1;
    localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] POS_FS = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [PHASE_W-1:0] start;
        logic [PHASE_W-1:0] step;
        logic [15:0]        count;
        logic [15:0]        dwell;
        logic               loop;
        logic [1:0]         wave;
        logic [AMP_W-1:0]   amp;
        logic [7:0]         duty;
        logic [DATA_W-1:0]  offset;
    } cfg_t;

    state_t             state_q, state_d;
    cfg_t               cur_q, cur_d, sh_q, sh_d, cfg_in;
    logic [PHASE_W-1:0] phase_q, phase_d, freq_q, freq_d;
    logic [15:0]        dwell_cnt_q, dwell_cnt_d, step_cnt_q, step_cnt_d, dwell_last;
    logic               pending_q, pending_d, done_q, done_d;
    logic               raw_v_q, raw_v_d, sc_v_q, sc_v_d;
    logic [DATA_W-1:0]  raw_q, raw_d, scaled_q, scaled_d, out_q, out_d;
    logic [DATA_W-1:0]  p, saw, tri_x, wave_val, y_out;
    logic [7:0]         h;
    logic [PHASE_W:0]   sum;
    logic signed [PW-1:0] prod;
    logic               accept, wrap, boundary, at_end;

    assign cfg_in = {cfg_freq_start, cfg_freq_step, cfg_step_count, cfg_dwell, cfg_loop,
                     cfg_wave, cfg_amp, cfg_duty, cfg_offset};

    assign accept     = cfg_valid && !pending_q && !(state_q == RUN && stop);
    assign sum        = {1'b0, phase_q} + {1'b0, freq_q};
    assign wrap       = sum[PHASE_W];
    assign dwell_last = (cur_q.dwell == 16'd0) ? 16'd0 : cur_q.dwell - 16'd1;
    assign boundary   = dwell_cnt_q == dwell_last;
    assign at_end     = step_cnt_q == cur_q.count;

    assign p     = phase_q[PHASE_W-1 -: DATA_W];
    assign h     = phase_q[PHASE_W-1 -: 8];
    assign saw   = {~p[DATA_W-1], p[DATA_W-2:0]};
    assign tri_x = {~p[DATA_W-2], p[DATA_W-3:0], 1'b0};
    assign wave_val = (cur_q.wave == 2'd0) ? saw :
                      (cur_q.wave == 2'd1) ? (p[DATA_W-1] ? ~tri_x : tri_x) :
                      ((h < cur_q.duty) ^ cur_q.wave[0]) ? POS_FS : MID;

    assign prod = $signed(raw_q) * $signed({1'b0, cur_q.amp});

`ifdef DDS_SWEEP_GEN_OFFSET_SAT_EN
    logic [DATA_W:0] y;
    assign y     = {scaled_q[DATA_W-1], scaled_q} + {cur_q.offset[DATA_W-1], cur_q.offset};
    assign y_out = (y[DATA_W] != y[DATA_W-1]) ? (y[DATA_W] ? MID : POS_FS) : y[DATA_W-1:0];
`else
    assign y_out = scaled_q + cur_q.offset;
`endif

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        sh_d        = sh_q;
        phase_d     = phase_q;
        freq_d      = freq_q;
        dwell_cnt_d = dwell_cnt_q;
        step_cnt_d  = step_cnt_q;
        pending_d   = pending_q;
        done_d      = done_q;
        raw_d       = raw_q;
        raw_v_d     = raw_v_q;
        scaled_d    = scaled_q;
        sc_v_d      = sc_v_q;
        out_d       = out_q;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d     = RUN;
                cur_d       = cfg_in;
                freq_d      = cfg_freq_start;
                phase_d     = '0;
                dwell_cnt_d = '0;
                step_cnt_d  = '0;
            end
        end else if (stop) begin
            state_d   = IDLE;
            phase_d   = '0;
            pending_d = 1'b0;
            done_d    = 1'b0;
            raw_v_d   = 1'b0;
            sc_v_d    = 1'b0;
            out_d     = MID;
        end else begin
            if (accept) begin
                sh_d      = cfg_in;
                pending_d = 1'b1;
            end
            if (ClkEn) begin
                phase_d     = sum[PHASE_W-1:0];
                raw_d       = wave_val;
                raw_v_d     = 1'b1;
                scaled_d    = DATA_W'(prod >>> AMP_W);
                sc_v_d      = raw_v_q;
                out_d       = sc_v_q ? {~y_out[DATA_W-1], y_out[DATA_W-2:0]} : MID;
                done_d      = 1'b0;
                dwell_cnt_d = boundary ? 16'd0 : dwell_cnt_q + 16'd1;
                // a retune at the wrap restarts the sweep and swallows any coincident step
                if (pending_q && wrap) begin
                    cur_d       = sh_q;
                    freq_d      = sh_q.start;
                    dwell_cnt_d = '0;
                    step_cnt_d  = '0;
                    pending_d   = 1'b0;
                end else if (boundary && !at_end) begin
                    freq_d     = freq_q + cur_q.step;
                    step_cnt_d = step_cnt_q + 16'd1;
                    done_d     = (step_cnt_q + 16'd1) == cur_q.count;
                end else if (boundary && cur_q.loop) begin
                    freq_d     = cur_q.start;
                    step_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            sh_q        <= '0;
            phase_q     <= '0;
            freq_q      <= '0;
            dwell_cnt_q <= '0;
            step_cnt_q  <= '0;
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
            raw_q       <= '0;
            raw_v_q     <= 1'b0;
            scaled_q    <= '0;
            sc_v_q      <= 1'b0;
            out_q       <= MID;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            sh_q        <= sh_d;
            phase_q     <= phase_d;
            freq_q      <= freq_d;
            dwell_cnt_q <= dwell_cnt_d;
            step_cnt_q  <= step_cnt_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
            raw_q       <= raw_d;
            raw_v_q     <= raw_v_d;
            scaled_q    <= scaled_d;
            sc_v_q      <= sc_v_d;
            out_q       <= out_d;
        end
    end

    assign cfg_ready  = !pending_q;
    assign busy       = state_q == RUN;
    assign sweep_done = done_q;
    assign freq_word  = freq_q;
    assign out        = out_q;
endmodule

// File: tb/tb_dds_sweep_gen.sv
// tb_dds_sweep_gen: directed checks of dds_sweep_gen with hand-computed expectations
module tb_dds_sweep_gen;
    logic        Clock = 1'b0;
    logic        Reset, ClkEn, cfg_valid, cfg_ready, cfg_loop, stop, busy, sweep_done;
    logic [31:0] cfg_freq_start, cfg_freq_step, freq_word;
    logic [15:0] cfg_step_count, cfg_dwell;
    logic [1:0]  cfg_wave;
    logic [7:0]  cfg_amp, cfg_duty;
    logic [11:0] cfg_offset, out;
    int          n_cmp = 0;
    int          n_bad = 0;

`ifdef DDS_SWEEP_GEN_OFFSET_SAT_EN
    localparam int HI_OFF = 4095;
`else
    localparam int HI_OFF = 91;
`endif

    dds_sweep_gen dut (
        .Clock(Clock), .Reset(Reset), .ClkEn(ClkEn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_freq_start(cfg_freq_start), .cfg_freq_step(cfg_freq_step), .cfg_step_count(cfg_step_count),
        .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop), .cfg_wave(cfg_wave), .cfg_amp(cfg_amp),
        .cfg_duty(cfg_duty), .cfg_offset(cfg_offset), .stop(stop), .busy(busy),
        .sweep_done(sweep_done), .freq_word(freq_word), .out(out)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] start, input logic [31:0] step, input logic [15:0] cnt,
                           input logic [15:0] dwell, input logic lp, input logic [1:0] wave,
                           input logic [7:0] amp, input logic [7:0] duty, input logic [11:0] offset);
        cfg_freq_start = start;
        cfg_freq_step  = step;
        cfg_step_count = cnt;
        cfg_dwell      = dwell;
        cfg_loop       = lp;
        cfg_wave       = wave;
        cfg_amp        = amp;
        cfg_duty       = duty;
        cfg_offset     = offset;
    endtask

    task automatic accept();
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic sweep_run(input logic lp);
        int k;
        set_cfg(32'h0100_0000, 32'h0100_0000, 16'd3, 16'd10, lp, 2'd0, 8'd255, 8'd0, 12'd0);
        accept();
        check("sweep_start", freq_word, 32'h0100_0000);
        for (int e = 1; e <= 45; e++) begin
            if (e == 10 && !lp) begin
                ClkEn = 1'b0;
                repeat (3) tick();
                check("clken_hold", freq_word, 32'h0100_0000);
                ClkEn = 1'b1;
            end
            tick();
            k = (e < 10) ? 1 : (e < 20) ? 2 : (e < 30) ? 3 : (e < 40 || !lp) ? 4 : 1;
            check(lp ? "freq_loop" : "freq_hold", freq_word, 32'(k) << 24);
            check("sweep_done", {31'd0, sweep_done}, {31'd0, e == 30});
        end
    endtask

    initial begin
        Reset = 1'b1; ClkEn = 1'b1; cfg_valid = 1'b0; stop = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("rst_out", out, 2048);
        check("rst_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", sweep_done, 0);
        check("rst_freq", freq_word, 0);
        Reset = 1'b0;

        set_cfg(32'h1000_0000, 0, 0, 1, 0, 2'd2, 8'd255, 8'd64, 12'd0);
        accept();
        check("run_busy", busy, 1);
        check("run_freq", freq_word, 32'h1000_0000);
        tick(); check("mid_e1", out, 2048);
        tick(); check("mid_e2", out, 2048);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("square", out, (i < 4) ? 4087 : 8);
        end

        set_cfg(32'h0100_0000, 0, 0, 1, 0, 2'd0, 8'd255, 8'd0, 12'd0);
        cfg_valid = 1'b1; stop = 1'b1;
        tick();
        cfg_valid = 1'b0; stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_out", out, 2048);
        check("stop_ready", cfg_ready, 1);
        check("stop_nocfg", freq_word, 32'h1000_0000);
        tick();
        check("idle_stays", busy, 0);

        set_cfg(32'h1000_0000, 0, 0, 1, 0, 2'd2, 8'd255, 8'd64, 12'd100);
        accept();
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            check("square_off", out, (i < 4) ? HI_OFF : 108);
        end

        set_cfg(32'h0400_0000, 0, 0, 1, 0, 2'd2, 8'd255, 8'd64, 12'd0);
        cfg_valid = 1'b1;
        tick();
        check("ready_drop", cfg_ready, 0);
        set_cfg(32'h0200_0000, 0, 0, 1, 0, 2'd2, 8'd255, 8'd64, 12'd0);
        tick();
        check("ready_pend", cfg_ready, 0);
        cfg_valid = 1'b0;
        repeat (11) tick();
        check("prewrap_freq", freq_word, 32'h1000_0000);
        check("prewrap_ready", cfg_ready, 0);
        tick();
        check("wrap_freq", freq_word, 32'h0400_0000);
        check("wrap_ready", cfg_ready, 1);
        stop = 1'b1; tick(); stop = 1'b0;

        sweep_run(1'b0);
        stop = 1'b1; tick(); stop = 1'b0;
        sweep_run(1'b1);

        Reset = 1'b1; tick(); Reset = 1'b0;
        check("mid_rst_out", out, 2048);
        check("mid_rst_ready", cfg_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", sweep_done, 0);
        check("mid_rst_freq", freq_word, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
